// File: rtl/imem_pkg.sv
// imem_pkg
// Shared definitions for the instruction-memory fetch controller.
//   state_t        : controller FSM states (load, idle, byte reads, error done)
//   BYTE_LANES     : bytes per instruction word
//   last_word_addr : highest aligned byte address that still holds a full word
package imem_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_IDLE = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned BYTE_LANES = 4;

    function automatic logic [31:0] last_word_addr(input int unsigned aw);
        return 32'((1 << aw) - BYTE_LANES);
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// imem_byte_ram
// Byte-wide synchronous single-port RAM, registered read (1-cycle latency).
// Contents have no reset and survive a controller reset.
// Ports:
//   i_clk   : clock
//   i_we    : write enable, writes i_wdata to i_addr on the rising edge
//   i_addr  : byte address (read and write share it)
//   i_wdata : write byte
//   o_rdata : byte at the address presented in the previous cycle
module imem_byte_ram #(
    parameter int AW = 7
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Boot-loads a program into a byte RAM from a byte-stream loader, then serves
// 32-bit instruction fetches as four sequential byte reads, byte at PC in [31:24].
// Optional feature macro: IMEM_RELOAD_EN (ld_start in S_IDLE re-enters S_LOAD).
// Ports:
//   i_clk, i_rst_n                : clock, asynchronous active-low reset
//   i_ld_valid/i_ld_data/i_ld_last: loader byte stream, o_ld_ready accepts
//   i_ld_start                    : reload request (only with IMEM_RELOAD_EN)
//   o_prog_loaded                 : program load finished
//   i_fetch_req/i_fetch_pc        : fetch request, held until accepted
//   o_fetch_busy                  : low only when a request can be accepted
//   o_fetch_valid                 : one-cycle pulse, o_fetch_instr/o_fetch_err valid
//   o_state                       : current FSM state (debug)
// Handshakes: a loader byte transfers on a rising edge where i_ld_valid and
// o_ld_ready are both high; a fetch is accepted on a rising edge where
// i_fetch_req is high and o_fetch_busy is low (and no reload wins that edge).
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_data,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    input  logic        i_ld_start,
    output logic        o_prog_loaded,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_pc,
    output logic        o_fetch_busy,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_instr,
    output logic        o_fetch_err,
    output state_t      o_state
);

    localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
    localparam logic [31:0]   LAST_WORD = last_word_addr(AW);
    localparam logic [2:0]    CNT_LAST  = 3'(BYTE_LANES);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_pc;
    logic [2:0]    r_cnt;
    logic [23:0]   r_shift;
    logic          r_ld_ready;
    logic          r_prog_loaded;
    logic          r_busy;
    logic          r_valid;
    logic          r_err;
    logic [31:0]   r_instr;

    logic          w_ld_fire;
    logic          w_we;
    logic [AW-1:0] w_ram_addr;
    logic [7:0]    w_rdata;
    logic          w_bad_pc;
    logic          w_reload;

`ifdef IMEM_RELOAD_EN
    assign w_reload = i_ld_start;
`else
    logic w_unused_ld_start;
    assign w_unused_ld_start = i_ld_start;
    assign w_reload = 1'b0;
`endif

    assign w_ld_fire = (r_state == S_LOAD) && i_ld_valid && r_ld_ready;
    assign w_we      = w_ld_fire;
    // Reads walk pc..pc+3; the extra count 4 re-reads pc and is discarded.
    assign w_ram_addr = (r_state == S_LOAD) ? r_addr : (r_pc + AW'(r_cnt[1:0]));
    assign w_bad_pc   = (i_fetch_pc[1:0] != 2'b00) || (i_fetch_pc > LAST_WORD);

    imem_byte_ram #(.AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_ram_addr),
        .i_wdata (i_ld_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_LOAD;
            r_addr        <= '0;
            r_pc          <= '0;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_ld_ready    <= 1'b1;
            r_prog_loaded <= 1'b0;
            r_busy        <= 1'b1;
            r_valid       <= 1'b0;
            r_err         <= 1'b0;
            r_instr       <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_ld_fire) begin
                        // The top address ends the load so the pointer never wraps.
                        if (i_ld_last || (r_addr == ADDR_MAX)) begin
                            r_state       <= S_IDLE;
                            r_prog_loaded <= 1'b1;
                            r_ld_ready    <= 1'b0;
                            r_busy        <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (w_reload) begin
                        r_state       <= S_LOAD;
                        r_addr        <= '0;
                        r_prog_loaded <= 1'b0;
                        r_ld_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                    end else if (i_fetch_req) begin
                        r_busy <= 1'b1;
                        r_pc   <= i_fetch_pc[AW-1:0];
                        r_cnt  <= '0;
                        if (w_bad_pc) begin
                            r_state <= S_DONE;
                            r_instr <= '0;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Read data lags the address by one cycle: counts 1..4 carry bytes 0..3.
                    if (r_cnt == CNT_LAST) begin
                        r_instr <= {r_shift, w_rdata};
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != 3'd0) begin
                        r_shift <= {r_shift[15:0], w_rdata};
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b1;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign o_ld_ready    = r_ld_ready;
    assign o_prog_loaded = r_prog_loaded;
    assign o_fetch_busy  = r_busy;
    assign o_fetch_valid = r_valid;
    assign o_fetch_instr = r_instr;
    assign o_fetch_err   = r_err;
    assign o_state       = r_state;

endmodule
